// File: rtl/tile_job_if.sv
// Host register-write port and typed job-word stream between the host, the
// tile_job_packer and the solver manager.
interface tile_job_if #(
    parameter int LIMB_INDEX_BITS = 6
);
    logic                       host_write_en;
    logic [1:0]                 host_write_sel;
    logic [LIMB_INDEX_BITS-1:0] host_write_index;
    logic [31:0]                host_write_data;
    logic                       host_commit;
    logic                       host_busy;
    logic                       host_overrun;
    logic                       fifo_valid;
    logic [2:0]                 fifo_data_type;
    logic [31:0]                fifo_data;
    logic                       fifo_ready;
    logic [15:0]                jobs_sent;

    // master: the packer itself; slave: host plus stream consumer
    modport master (
        input  host_write_en, host_write_sel, host_write_index, host_write_data,
               host_commit, fifo_ready,
        output host_busy, host_overrun, fifo_valid, fifo_data_type, fifo_data,
               jobs_sent
    );
    modport slave (
        output host_write_en, host_write_sel, host_write_index, host_write_data,
               host_commit, fifo_ready,
        input  host_busy, host_overrun, fifo_valid, fifo_data_type, fifo_data,
               jobs_sent
    );
endinterface

// File: rtl/tile_job_packer.sv
// Buffers one tile job written by the host and serialises it as typed words
// (addr, zoom, real limbs, imag limbs, start) for the solver manager.
module tile_job_packer #(
    parameter int NUM_LIMBS       = 4,
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 27,
    parameter int POST_START_GAP  = 2
) (
    input  logic       clock,
    input  logic       reset,
    tile_job_if.master bus
);
    localparam int CNT_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
    localparam int GAP_W = (POST_START_GAP > 1) ? $clog2(POST_START_GAP) : 1;
    localparam logic [31:0]      LIMB_MASK = 32'((64'd1 << LIMB_SIZE_BITS) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NUM_LIMBS - 1);
    localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(POST_START_GAP - 1);

    typedef enum logic [2:0] {IDLE, ADDR, ZOOM, REAL, IMAG, START, GAP} state_t;

    state_t           state, state_n;
    logic [31:0]      output_addr, zoom_level;
    logic [31:0]      real_limbs [NUM_LIMBS];
    logic [31:0]      imag_limbs [NUM_LIMBS];
    logic [CNT_W-1:0] limb_cnt, limb_cnt_n, limb_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic             valid_q, valid_n;
    logic [2:0]       type_q, type_n;
    logic [31:0]      data_q, data_n;
    logic [15:0]      jobs_q, jobs_n;
    logic             overrun_q;
    logic             idle, xfer;
    logic [31:0]      addr_eff;

    assign idle     = (state == IDLE);
    assign xfer     = valid_q & bus.fifo_ready;
    assign limb_nxt = limb_cnt + CNT_W'(1);

    // A write landing in the commit cycle must already be visible in the first word
    assign addr_eff = (bus.host_write_en && bus.host_write_sel == 2'd0)
                      ? bus.host_write_data : output_addr;

    always_comb begin
        state_n    = state;
        limb_cnt_n = limb_cnt;
        gap_cnt_n  = gap_cnt;
        valid_n    = valid_q;
        type_n     = type_q;
        data_n     = data_q;
        jobs_n     = jobs_q;
        unique case (state)
            IDLE: if (bus.host_commit) begin
                state_n = ADDR;
                valid_n = 1'b1;
                type_n  = 3'd0;
                data_n  = addr_eff;
            end
            ADDR: if (xfer) begin
                state_n = ZOOM;
                type_n  = 3'd1;
                data_n  = zoom_level;
            end
            ZOOM: if (xfer) begin
                state_n    = REAL;
                limb_cnt_n = '0;
                type_n     = 3'd2;
                data_n     = real_limbs[0];
            end
            REAL: if (xfer) begin
                if (limb_cnt == LAST_LIMB) begin
                    state_n    = IMAG;
                    limb_cnt_n = '0;
                    type_n     = 3'd3;
                    data_n     = imag_limbs[0];
                end else begin
                    limb_cnt_n = limb_nxt;
                    data_n     = real_limbs[limb_nxt];
                end
            end
            IMAG: if (xfer) begin
                if (limb_cnt == LAST_LIMB) begin
                    state_n = START;
                    type_n  = 3'd4;
                    data_n  = '0;
                end else begin
                    limb_cnt_n = limb_nxt;
                    data_n     = imag_limbs[limb_nxt];
                end
            end
            START: if (xfer) begin
                state_n   = GAP;
                valid_n   = 1'b0;
                gap_cnt_n = '0;
                jobs_n    = jobs_q + 16'd1;
            end
            // Consumer ready may still read stale-high here, so nothing is offered
            GAP: begin
                gap_cnt_n = gap_cnt + GAP_W'(1);
                if (gap_cnt == LAST_GAP) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            limb_cnt    <= '0;
            gap_cnt     <= '0;
            valid_q     <= 1'b0;
            type_q      <= '0;
            data_q      <= '0;
            jobs_q      <= '0;
            overrun_q   <= 1'b0;
            output_addr <= '0;
            zoom_level  <= '0;
            for (int k = 0; k < NUM_LIMBS; k++) begin
                real_limbs[k] <= '0;
                imag_limbs[k] <= '0;
            end
        end else begin
            state     <= state_n;
            limb_cnt  <= limb_cnt_n;
            gap_cnt   <= gap_cnt_n;
            valid_q   <= valid_n;
            type_q    <= type_n;
            data_q    <= data_n;
            jobs_q    <= jobs_n;
            overrun_q <= !idle && (bus.host_write_en || bus.host_commit);
            if (idle && bus.host_write_en) begin
                unique case (bus.host_write_sel)
                    2'd0: output_addr <= bus.host_write_data;
                    2'd1: zoom_level  <= bus.host_write_data;
                    default: begin
                        // Out-of-range indices match no slot and fall away silently
                        for (int k = 0; k < NUM_LIMBS; k++) begin
                            if (bus.host_write_index == LIMB_INDEX_BITS'(k)) begin
                                if (bus.host_write_sel == 2'd2)
                                    real_limbs[k] <= bus.host_write_data & LIMB_MASK;
                                else
                                    imag_limbs[k] <= bus.host_write_data & LIMB_MASK;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.fifo_valid     = valid_q;
    assign bus.fifo_data_type = type_q;
    assign bus.fifo_data      = data_q;
    assign bus.jobs_sent      = jobs_q;
    assign bus.host_busy      = !idle;
    assign bus.host_overrun   = overrun_q;
endmodule

// File: tb/tb_tile_job_packer.sv
// Directed plus randomized bench for tile_job_packer; the expected word stream
// comes from a plain array model of the host-visible job buffer.
module tb_tile_job_packer;
    localparam int NL   = 4;
    localparam int GAP  = 2;
    localparam logic [31:0] MASK = 32'h07FF_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    tile_job_if #(.LIMB_INDEX_BITS(6)) bus ();

    tile_job_packer #(
        .NUM_LIMBS(NL), .LIMB_INDEX_BITS(6), .LIMB_SIZE_BITS(27), .POST_START_GAP(GAP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_pass   = 0;
    int n_checks = 0;

    logic [31:0] m_addr, m_zoom;
    logic [31:0] m_real [NL];
    logic [31:0] m_imag [NL];
    int          m_jobs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void model_clear();
        m_addr = '0;
        m_zoom = '0;
        for (int k = 0; k < NL; k++) begin
            m_real[k] = '0;
            m_imag[k] = '0;
        end
        m_jobs = 0;
    endfunction

    function automatic void model_write(input logic [1:0] sel, input int idx, input logic [31:0] d);
        case (sel)
            2'd0: m_addr = d;
            2'd1: m_zoom = d;
            2'd2: if (idx < NL) m_real[idx] = d & MASK;
            default: if (idx < NL) m_imag[idx] = d & MASK;
        endcase
    endfunction

    task automatic host_write(input logic [1:0] sel, input int idx, input logic [31:0] d);
        bus.host_write_en    = 1'b1;
        bus.host_write_sel   = sel;
        bus.host_write_index = 6'(idx);
        bus.host_write_data  = d;
        model_write(sel, idx, d);
        tick();
        bus.host_write_en = 1'b0;
    endtask

    // Commit (with any write already set up on the port) and follow the job
    // through stream, gap and return to idle.
    task automatic run_job(input string tag, input bit rnd_ready, input bit inject_ov);
        logic [34:0] exp [$];
        logic [34:0] prev;
        bit          stalled = 0;
        bit          ov_exp  = 0;
        bit          rdy;
        int          idx = 0;
        int          cyc = 0;
        if (bus.host_write_en)
            model_write(bus.host_write_sel, int'(bus.host_write_index), bus.host_write_data);
        exp.push_back({3'd0, m_addr});
        exp.push_back({3'd1, m_zoom});
        for (int k = 0; k < NL; k++) exp.push_back({3'd2, m_real[k]});
        for (int k = 0; k < NL; k++) exp.push_back({3'd3, m_imag[k]});
        exp.push_back({3'd4, 32'd0});

        bus.host_commit = 1'b1;
        tick();
        bus.host_commit   = 1'b0;
        bus.host_write_en = 1'b0;
        check({tag, "_busy_rise"}, 64'(bus.host_busy), 64'd1);

        while (idx < exp.size() && cyc < 200) begin
            check({tag, "_valid"}, 64'(bus.fifo_valid), 64'd1);
            check({tag, "_overrun"}, 64'(bus.host_overrun), 64'(ov_exp));
            if (stalled)
                check({tag, "_stall_hold"}, 64'({bus.fifo_data_type, bus.fifo_data}), 64'(prev));
            ov_exp = 0;
            if (inject_ov && (cyc == 3 || cyc == 4)) begin
                bus.host_write_en    = 1'b1;
                bus.host_write_sel   = 2'd0;
                bus.host_write_index = '0;
                bus.host_write_data  = 32'hDEAD;
                bus.host_commit      = 1'b1;
                ov_exp = 1;
            end
            rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.fifo_ready = rdy;
            if (rdy) begin
                check({tag, "_word"}, 64'({bus.fifo_data_type, bus.fifo_data}), 64'(exp[idx]));
                idx++;
                stalled = 0;
            end else begin
                prev    = {bus.fifo_data_type, bus.fifo_data};
                stalled = 1;
            end
            tick();
            bus.host_write_en = 1'b0;
            bus.host_commit   = 1'b0;
            cyc++;
        end
        check({tag, "_all_words"}, 64'(idx), 64'(exp.size()));
        if (!rnd_ready) check({tag, "_len"}, 64'(cyc), 64'(2 * NL + 3));
        m_jobs++;

        for (int g = 0; g < GAP; g++) begin
            check({tag, "_gap_valid"}, 64'(bus.fifo_valid), 64'd0);
            check({tag, "_gap_busy"}, 64'(bus.host_busy), 64'd1);
            bus.fifo_ready = 1'b1;
            tick();
        end
        check({tag, "_busy_fall"}, 64'(bus.host_busy), 64'd0);
        check({tag, "_idle_valid"}, 64'(bus.fifo_valid), 64'd0);
        check({tag, "_jobs"}, 64'(bus.jobs_sent), 64'(m_jobs & 16'hFFFF));
    endtask

    initial begin
        bus.host_write_en    = 1'b0;
        bus.host_write_sel   = '0;
        bus.host_write_index = '0;
        bus.host_write_data  = '0;
        bus.host_commit      = 1'b0;
        bus.fifo_ready       = 1'b0;
        model_clear();
        tick();
        tick();
        check("rst_valid", 64'(bus.fifo_valid), 64'd0);
        check("rst_type", 64'(bus.fifo_data_type), 64'd0);
        check("rst_data", 64'(bus.fifo_data), 64'd0);
        check("rst_busy", 64'(bus.host_busy), 64'd0);
        check("rst_overrun", 64'(bus.host_overrun), 64'd0);
        check("rst_jobs", 64'(bus.jobs_sent), 64'd0);
        reset = 1'b0;
        tick();

        // basic job; limb 3 carries junk above bit 26 that must be dropped
        host_write(2'd0, 0, 32'h1000);
        host_write(2'd1, 0, 32'd5);
        for (int k = 0; k < NL; k++)
            host_write(2'd2, k, (k == 3) ? 32'hF800_0004 : 32'(k + 1));
        for (int k = 0; k < NL; k++) host_write(2'd3, k, 32'(32'h11 + k));
        run_job("basic", 1'b0, 1'b0);
        run_job("b2b", 1'b0, 1'b0);
        run_job("bp", 1'b1, 1'b0);
        run_job("ovr", 1'b1, 1'b1);
        run_job("post_ovr", 1'b0, 1'b0);

        // boundary: out-of-range index ignored, write+commit in one cycle
        host_write(2'd2, 4, 32'h999);
        host_write(2'd3, 63, 32'h555);
        bus.host_write_en    = 1'b1;
        bus.host_write_sel   = 2'd2;
        bus.host_write_index = 6'd0;
        bus.host_write_data  = 32'h07FF_FFFF;
        run_job("bnd_limb", 1'b0, 1'b0);
        bus.host_write_en    = 1'b1;
        bus.host_write_sel   = 2'd0;
        bus.host_write_data  = 32'h2000;
        run_job("bnd_addr", 1'b1, 1'b0);

        // reset during REAL: job abandoned, buffer and counter cleared
        bus.fifo_ready  = 1'b1;
        bus.host_commit = 1'b1;
        tick();
        bus.host_commit = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_in_real", 64'(bus.fifo_data_type), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check("mid_valid", 64'(bus.fifo_valid), 64'd0);
        check("mid_busy", 64'(bus.host_busy), 64'd0);
        check("mid_jobs", 64'(bus.jobs_sent), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("mid_quiet", 64'(bus.fifo_valid), 64'd0);
            tick();
        end
        run_job("zero_job", 1'b0, 1'b0);

        // randomized buffer contents, including out-of-range limb indices
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 12; w++)
                host_write(2'($urandom_range(0, 3)), $urandom_range(0, 5), $urandom);
            run_job("rand", 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
